axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_timeout_counter.sv | 34 +++
 rtl/axil_cmd_master.sv | 163 ++++++++++++++++
 tb/tb_axil_cmd_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Holds the FSM state encoding, the AXI response codes and a bus-state helper.
// No ports; imported by the master top.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RSP          = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // States in which the master is waiting on the AXI slave and the
  // phase timeout is running.
  function automatic logic is_bus_state(input state_t st);
    return (st == ST_WR_ADDR_DATA) || (st == ST_WR_RESP) ||
           (st == ST_RD_ADDR)      || (st == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_timeout_counter.sv
// Purpose: counts cycles spent in one bus phase; flags the last allowed cycle.
// Latency: expired is combinational from the count (high on cycle timeout_cycles-1 of a phase).
// Backpressure: none; clear restarts the count, enable advances it, timeout_cycles=0 never expires.
// Ports: clk, rst_n, clear (phase change), enable (in a bus phase), expired.
module axil_timeout_counter #(
  parameter int timeout_cycles = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] LAST = CW'((timeout_cycles > 0) ? (timeout_cycles - 1) : 0);

  logic [CW-1:0] cnt_q;

  // Saturates at LAST so a phase that is held past expiry (handshake won
  // the tie) cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (timeout_cycles != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// Purpose: turns single read/write commands into AXI4-Lite transactions, one outstanding.
// Latency: command to AXI valid 1 cycle; response valid 1 cycle after the b/r handshake or timeout.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; per-phase timeout aborts stuck slaves.
// Ports: cmd_* command in, rsp_* response out, m_axi_* AXI4-Lite master channels (aw, w, b, ar, r).
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int axi_width      = 32,
  parameter int timeout_cycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [11:0]            cmd_addr,
  input  logic [axi_width-1:0]   cmd_wdata,
  input  logic [axi_width/8-1:0] cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [axi_width-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_timeout,
  output logic [11:0]            m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [axi_width-1:0]   m_axi_wdata,
  output logic [axi_width/8-1:0] m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [11:0]            m_axi_araddr,
  output logic [2:0]             m_axi_arprot,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [axi_width-1:0]   m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int SW = axi_width / 8;

  state_t               state_q, state_d;
  logic                 rdy_en_q;
  logic [11:0]          addr_q;
  logic [axi_width-1:0] wdata_q;
  logic [SW-1:0]        wstrb_q;
  logic                 aw_done_q, w_done_q;
  logic [axi_width-1:0] rsp_rdata_q;
  logic [1:0]           rsp_resp_q;
  logic                 rsp_timeout_q;
  logic                 expired;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic aw_done_n, w_done_n;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign aw_fire   = m_axi_awvalid & m_axi_awready;
  assign w_fire    = m_axi_wvalid & m_axi_wready;
  assign b_fire    = m_axi_bvalid & m_axi_bready;
  assign ar_fire   = m_axi_arvalid & m_axi_arready;
  assign r_fire    = m_axi_rvalid & m_axi_rready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  // Address and data handshakes complete independently; include this cycle's.
  assign aw_done_n = aw_done_q | aw_fire;
  assign w_done_n  = w_done_q | w_fire;

  // A state change restarts the phase timer.
  axil_timeout_counter #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_d != state_q),
    .enable (is_bus_state(state_q)),
    .expired(expired)
  );

  // State register plus latched command / response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rdy_en_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Keeps cmd_ready low while reset is held even though the state is IDLE.
      rdy_en_q <= 1'b1;
      if (cmd_fire) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      // Handshakes are checked before the timeout so they win a tie.
      if ((state_q == ST_WR_RESP) && b_fire) begin
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= m_axi_bresp;
        rsp_timeout_q <= 1'b0;
      end else if ((state_q == ST_RD_DATA) && r_fire) begin
        rsp_rdata_q   <= m_axi_rdata;
        rsp_resp_q    <= m_axi_rresp;
        rsp_timeout_q <= 1'b0;
      end else if ((state_d == ST_RSP) && (state_q != ST_RSP)) begin
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (cmd_fire) state_d = cmd_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      ST_WR_ADDR_DATA: if (aw_done_n && w_done_n) state_d = ST_WR_RESP;
                       else if (expired)          state_d = ST_RSP;
      ST_WR_RESP:      if (b_fire || expired)     state_d = ST_RSP;
      ST_RD_ADDR:      if (ar_fire)               state_d = ST_RD_DATA;
                       else if (expired)          state_d = ST_RSP;
      ST_RD_DATA:      if (r_fire || expired)     state_d = ST_RSP;
      ST_RSP:          if (rsp_fire)              state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; all payloads come from registers.
  always_comb begin
    cmd_ready     = (state_q == ST_IDLE) && rdy_en_q;
    m_axi_awvalid = (state_q == ST_WR_ADDR_DATA) && !aw_done_q;
    m_axi_wvalid  = (state_q == ST_WR_ADDR_DATA) && !w_done_q;
    m_axi_bready  = (state_q == ST_WR_RESP);
    m_axi_arvalid = (state_q == ST_RD_ADDR);
    m_axi_rready  = (state_q == ST_RD_DATA);
    rsp_valid     = (state_q == ST_RSP);
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_awprot  = 3'b000;
    m_axi_arprot  = 3'b000;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = wstrb_q;
    rsp_rdata     = rsp_rdata_q;
    rsp_resp      = rsp_resp_q;
    rsp_timeout   = rsp_timeout_q;
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: inputs driven and outputs sampled on the falling edge.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(.axi_width(32), .timeout_cycles(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Handshake counters on the AXI channels.
  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (bvalid && bready)   b_cnt  <= b_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
  end

  // Waits (bounded) for cmd_ready, presents one command for a single cycle.
  // Called and returns on a falling edge; the DUT holds the command afterwards.
  task automatic issue_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: ctrl=%b required 0", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
    end
    total++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_timeout} !== '0) begin
      bad++; $display("FAIL reset_data: awaddr=%h wdata=%h rsp_rdata=%h rsp_resp=%b required 0", awaddr, wdata, rsp_rdata, rsp_resp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
    awready = 1; wready = 1;
    issue_cmd(1'b1, 12'h010, 32'h0000_0001, 4'hF);
    total++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb, awprot} !== {1'b1, 1'b1, 12'h010, 32'h1, 4'hF, 3'b000}) begin
      bad++; $display("FAIL wr_basic_req: awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%h awprot=%b required 1 1 010 00000001 f 000",
                      awvalid, wvalid, awaddr, wdata, wstrb, awprot);
    end
    @(negedge clk);
    awready = 0; wready = 0;
    total++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      bad++; $display("FAIL wr_basic_wresp: awvalid/wvalid/bready=%b required 001", {awvalid, wvalid, bready});
    end
    bvalid = 1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 0;
    total++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, bready} !== {1'b1, 2'b00, 1'b0, 32'h0, 1'b0}) begin
      bad++; $display("FAIL wr_basic_rsp: rsp_valid=%b rsp_resp=%b rsp_timeout=%b rsp_rdata=%h required 1 00 0 0",
                      rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    total++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL wr_basic_once: aw=%0d w=%0d b=%0d required 1 1 1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL wr_basic_idle: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_wait();
    arready = 1;
    issue_cmd(1'b0, 12'h020, 32'h0, 4'h0);
    total++;
    if ({arvalid, araddr, arprot} !== {1'b1, 12'h020, 3'b000}) begin
      bad++; $display("FAIL rd_ar: arvalid=%b araddr=%h arprot=%b required 1 020 000", arvalid, araddr, arprot);
    end
    @(negedge clk);
    arready = 0;
    total++;
    if ({arvalid, rready} !== 2'b01) begin
      bad++; $display("FAIL rd_rready: arvalid/rready=%b required 01", {arvalid, rready});
    end
    repeat (4) @(negedge clk);
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    @(negedge clk);
    rvalid = 0; rdata = '0;
    total++;
    if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, rready} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rd_rsp: rsp_valid=%b rsp_rdata=%h rsp_resp=%b rsp_timeout=%b required 1 deadbeef 00 0",
                      rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_write_w_first();
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
    int errs = 0;
    awready = 0; wready = 1;
    issue_cmd(1'b1, 12'h104, 32'hA5A5_5A5A, 4'h3);
    total++;
    if ({awvalid, wvalid, wdata, wstrb} !== {1'b1, 1'b1, 32'hA5A5_5A5A, 4'h3}) begin
      bad++; $display("FAIL wfirst_req: awvalid=%b wvalid=%b wdata=%h wstrb=%h required 1 1 a5a55a5a 3", awvalid, wvalid, wdata, wstrb);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wready = 0;
      if ({awvalid, wvalid, awaddr, bready} !== {1'b1, 1'b0, 12'h104, 1'b0}) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL wfirst_hold: %0d cycles wrong, required awvalid held with wvalid low", errs); end
    awready = 1;
    @(negedge clk);
    awready = 0;
    total++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      bad++; $display("FAIL wfirst_wresp: awvalid/wvalid/bready=%b required 001", {awvalid, wvalid, bready});
    end
    bvalid = 1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 0; bresp = 2'b00;
    total++;
    if ({rsp_valid, rsp_resp, rsp_timeout} !== {1'b1, 2'b10, 1'b0}) begin
      bad++; $display("FAIL wfirst_rsp: rsp_valid=%b rsp_resp=%b rsp_timeout=%b required 1 10 0", rsp_valid, rsp_resp, rsp_timeout);
    end
    total++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL wfirst_once: aw=%0d w=%0d b=%0d required 1 1 1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  // Leaves the DUT holding a timeout response in RSP.
  task automatic test_timeout();
    int errs = 0;
    arready = 0;
    issue_cmd(1'b0, 12'h030, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      if ({arvalid, rsp_valid} !== 2'b10) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL timeout_wait: %0d of 16 cycles wrong, required arvalid=1 rsp_valid=0", errs); end
    total++;
    if ({rsp_valid, arvalid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 2'b10, 1'b1, 32'h0}) begin
      bad++; $display("FAIL timeout_rsp: rsp_valid=%b arvalid=%b rsp_resp=%b rsp_timeout=%b rsp_rdata=%h required 1 0 10 1 0",
                      rsp_valid, arvalid, rsp_resp, rsp_timeout, rsp_rdata);
    end
  endtask

  task automatic test_rsp_backpressure();
    int errs = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h0AA; cmd_wdata = 32'h0000_1234; cmd_wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, cmd_ready, awvalid, arvalid}
          !== {1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL bp_hold: %0d of 10 cycles wrong, required stable rsp and blocked cmd", errs); end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
    end
    @(negedge clk);
    cmd_valid = 0;
    total++;
    if ({awvalid, wvalid, awaddr, wdata, cmd_ready} !== {1'b1, 1'b1, 12'h0AA, 32'h1234, 1'b0}) begin
      bad++; $display("FAIL bp_next_cmd: awvalid=%b wvalid=%b awaddr=%h wdata=%h required 1 1 0aa 00001234", awvalid, wvalid, awaddr, wdata);
    end
    awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 0;
    total++;
    if ({rsp_valid, rsp_resp, rsp_timeout} !== {1'b1, 2'b00, 1'b0}) begin
      bad++; $display("FAIL bp_timeout_clear: rsp_valid=%b rsp_resp=%b rsp_timeout=%b required 1 00 0", rsp_valid, rsp_resp, rsp_timeout);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    int b0;
    int errs = 0;
    awready = 1; wready = 1;
    issue_cmd(1'b1, 12'h040, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    awready = 0; wready = 0;
    total++;
    if (bready !== 1'b1) begin bad++; $display("FAIL rstmid_wresp: bready=%b required 1", bready); end
    b0 = b_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, rsp_valid, bready, awvalid, wvalid, awaddr, wdata, rsp_resp, rsp_timeout} !== '0) begin
      bad++; $display("FAIL rstmid_async: cmd_ready=%b rsp_valid=%b bready=%b awaddr=%h wdata=%h required all 0",
                      cmd_ready, rsp_valid, bready, awaddr, wdata);
    end
    bvalid = 1;
    repeat (2) @(negedge clk);
    bvalid = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({rsp_valid, cmd_ready} !== 2'b01) errs++;
    end
    total++;
    if (errs != 0 || b_cnt != b0) begin
      bad++; $display("FAIL rstmid_release: %0d cycles wrong, b handshakes=%0d, required cmd_ready=1 rsp_valid=0 no b", errs, b_cnt - b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_w_first();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
